cpu_ctrl_fsm: RTL

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

---
 rtl/cpu_ctrl_fsm.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle instruction controller (IDLE/DECODE/EXEC/MEM/WB)
// Optional retired-instruction counter: define CPU_CTRL_PERF_CNT_EN.
module cpu_ctrl_fsm #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_ready,
  output logic [1:0]             rf_ra1,
  output logic [1:0]             rf_ra2,
  output logic [1:0]             rf_wa,
  output logic                   rf_we,
  output logic                   alu_op,
  output logic                   alu_b_imm,
  output logic [7:0]             imm,
  output logic                   dmem_re,
  output logic                   dmem_we,
  output logic                   wb_sel_mem,
`ifdef CPU_CTRL_PERF_CNT_EN
  output logic [15:0]            retired_cnt,
`endif
  output logic                   done,
  output logic                   illegal
);

  if (INSTR_WIDTH != 20 || DATA_WIDTH < 8 || ADDR_BITS > DATA_WIDTH) begin : g_bad_cfg
    $error("cpu_ctrl_fsm: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [1:0] CLS_NOP   = 2'b00;
  localparam logic [1:0] CLS_ALU   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;

  logic [1:0] cls, x1, x2, x3;
  logic [7:0] offset;
  logic [3:0] funct;
  logic       funct_bad;

  assign cls       = instr_q[19:18];
  assign x1        = instr_q[17:16];
  assign x2        = instr_q[15:14];
  assign x3        = instr_q[13:12];
  assign offset    = instr_q[11:4];
  assign funct     = instr_q[3:0];
  assign funct_bad = (funct > 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // Sequencing and strobes; only the latched copy of the instruction is decoded.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    rf_wa       = 2'b00;
    dmem_re     = 1'b0;
    dmem_we     = 1'b0;
    wb_sel_mem  = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instruction;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (cls == CLS_NOP) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cls == CLS_ALU) begin
          if (funct_bad) begin
            illegal = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WB;
          end
        end else if (cls == CLS_LOAD || cls == CLS_STORE) begin
          state_d = MEM;
        end else begin
          state_d = IDLE;
        end
      end
      MEM: begin
        if (cls == CLS_LOAD) begin
          dmem_re = 1'b1;
          state_d = WB;
        end else begin
          dmem_we = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      WB: begin
        rf_we      = 1'b1;
        rf_wa      = x1;
        wb_sel_mem = (cls == CLS_LOAD);
        done       = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand selection is held stable from EXEC through the last active state.
  always_comb begin
    rf_ra1    = 2'b00;
    rf_ra2    = 2'b00;
    alu_op    = 1'b0;
    alu_b_imm = 1'b0;
    imm       = 8'h00;
    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      case (cls)
        CLS_ALU: begin
          rf_ra1 = x2;
          rf_ra2 = x3;
          alu_op = funct[0];
        end
        CLS_LOAD: begin
          rf_ra1    = x2;
          alu_b_imm = 1'b1;
          imm       = offset;
        end
        CLS_STORE: begin
          rf_ra1    = x2;
          rf_ra2    = x1;
          alu_b_imm = 1'b1;
          imm       = offset;
        end
        default: ;
      endcase
    end
  end

`ifdef CPU_CTRL_PERF_CNT_EN
  logic [15:0] retired_cnt_q, retired_cnt_d;

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (done) retired_cnt_d = retired_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) retired_cnt_q <= 16'd0;
    else      retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;
`endif

endmodule
